// File: rtl/demux_rr_dispatcher.sv
// demux_rr_dispatcher: sequencing controller for a 1-to-4 demux datapath.
// Accepts a valid/ready word stream into a single-entry holding buffer and
// offers each held word to one channel at a time. Channels are chosen
// round-robin over the enabled ones. A channel that stalls for TIMEOUT
// cycles, or that becomes disabled, is skipped.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   chan_en[3:0]   per-channel enable
//   in_valid/in_ready/in_data    producer handshake and word
//   out_data       held word, shared by all channels
//   out_valid[3:0] one-hot valid for the selected channel
//   out_ready[3:0] per-channel ready
//   sel[1:0]       current target channel (demux select)
//   busy           a word is held
//   err_no_chan    a word is held while no channel is enabled
//
// Optional macro DEMUX_RR_DISPATCHER_STATS_EN adds the parameter CW and the
// outputs xfer_cnt[4*CW-1:0] (per-channel delivered words) and
// reroute_cnt[CW-1:0] (timeout and disable reroutes). Both saturate.
module demux_rr_dispatcher #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 15
`ifdef DEMUX_RR_DISPATCHER_STATS_EN
  ,
  parameter int unsigned CW      = 8
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       chan_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [1:0]       sel,
  output logic             busy,
  output logic             err_no_chan
`ifdef DEMUX_RR_DISPATCHER_STATS_EN
  ,
  output logic [4*CW-1:0]  xfer_cnt,
  output logic [CW-1:0]    reroute_cnt
`endif
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_HOLD = 1'b1;
  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic             state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             deliver;
  logic             timeout_hit;

  // First enabled channel searching start, start+1, start+2, start+3 (mod 4).
  function automatic logic [1:0] first_en(input logic [1:0] start, input logic [3:0] en);
    logic [1:0] c;
    first_en = start;
    for (int k = 3; k >= 0; k--) begin
      c = start + 2'(k);
      if (en[c]) first_en = c;
    end
  endfunction

  assign deliver     = (state_q == ST_HOLD) && chan_en[sel_q] && out_ready[sel_q];
  assign timeout_hit = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1));

  // Handshake outputs follow chan_en directly so a disabled channel never sees valid.
  assign in_ready    = (state_q == ST_IDLE) && (chan_en != 4'b0000);
  assign out_valid   = (state_q == ST_HOLD) ? ((4'b0001 << sel_q) & chan_en) : 4'b0000;
  assign out_data    = data_q;
  assign sel         = sel_q;
  assign busy        = (state_q == ST_HOLD);
  assign err_no_chan = (state_q == ST_HOLD) && (chan_en == 4'b0000);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
    end
  end

  // Next state: accept, deliver, skip disabled channel, or time out.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          data_d  = in_data;
          timer_d = '0;
          sel_d   = first_en(ptr_q, chan_en);
          state_d = ST_HOLD;
        end
      end
      default: begin
        if (deliver) begin
          ptr_d   = sel_q + 2'd1;
          timer_d = '0;
          state_d = ST_IDLE;
        end else if (chan_en == 4'b0000) begin
          // Nothing to reroute to; wait for an enable.
          timer_d = timer_q;
        end else if (!chan_en[sel_q]) begin
          sel_d   = first_en(sel_q + 2'd1, chan_en);
          timer_d = '0;
        end else if (TIMEOUT != 0) begin
          if (timeout_hit) begin
            // Searching from sel+1 wraps back to sel when it is the only enabled channel.
            sel_d   = first_en(sel_q + 2'd1, chan_en);
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
    endcase
  end

`ifdef DEMUX_RR_DISPATCHER_STATS_EN
  logic reroute;

  assign reroute = (state_q == ST_HOLD) && !deliver && (chan_en != 4'b0000) &&
                   (!chan_en[sel_q] || timeout_hit);

  // Saturating delivery and reroute counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xfer_cnt    <= '0;
      reroute_cnt <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (deliver && (sel_q == 2'(i)) && (xfer_cnt[i*CW +: CW] != {CW{1'b1}}))
          xfer_cnt[i*CW +: CW] <= xfer_cnt[i*CW +: CW] + CW'(1);
      end
      if (reroute && (reroute_cnt != {CW{1'b1}}))
        reroute_cnt <= reroute_cnt + CW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Self-checking bench for demux_rr_dispatcher: directed scenarios followed by
// randomized traffic, every cycle compared against a transaction-level model.
module tb_demux_rr_dispatcher;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 15;
`ifdef DEMUX_RR_DISPATCHER_STATS_EN
  localparam int CW      = 2;
  localparam int SAT     = (1 << CW) - 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       chan_en;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [1:0]       sel;
  logic             busy;
  logic             err_no_chan;
`ifdef DEMUX_RR_DISPATCHER_STATS_EN
  logic [4*CW-1:0]  xfer_cnt;
  logic [CW-1:0]    reroute_cnt;
`endif

  demux_rr_dispatcher #(
    .WIDTH(WIDTH),
    .TIMEOUT(TIMEOUT)
`ifdef DEMUX_RR_DISPATCHER_STATS_EN
    ,
    .CW(CW)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .chan_en(chan_en),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sel(sel),
    .busy(busy),
    .err_no_chan(err_no_chan)
`ifdef DEMUX_RR_DISPATCHER_STATS_EN
    ,
    .xfer_cnt(xfer_cnt),
    .reroute_cnt(reroute_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: one held word, its target channel, the round-robin
  // pointer and how long the current target has stalled.
  bit         m_held;
  logic [7:0] m_word;
  int         m_tgt;
  int         m_ptr;
  int         m_stall;
  int         m_xfer[4];
  int         m_rr;

  function automatic int m_first(input int start, input logic [3:0] en);
    for (int k = 0; k < 4; k++) begin
      if (en[(start + k) % 4]) return (start + k) % 4;
    end
    return start % 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [3:0] exp_ov;
    exp_ov = m_held ? (4'(1 << m_tgt) & chan_en) : 4'b0000;
    chk("in_ready", 32'(in_ready), 32'(!m_held && (chan_en != 4'b0000)));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("out_data", 32'(out_data), 32'(m_word));
    chk("busy", 32'(busy), 32'(m_held));
    chk("err_no_chan", 32'(err_no_chan), 32'(m_held && (chan_en == 4'b0000)));
    chk("sel", 32'(sel), 32'(m_tgt));
`ifdef DEMUX_RR_DISPATCHER_STATS_EN
    for (int i = 0; i < 4; i++) chk("xfer_cnt", 32'(xfer_cnt[i*CW +: CW]), 32'(m_xfer[i]));
    chk("reroute_cnt", 32'(reroute_cnt), 32'(m_rr));
`endif
  endtask

  // One clock: predict from the inputs present before the edge, then compare.
  task automatic step();
    bit         h;
    logic [7:0] w;
    int         t, p, s;
    bit         do_x, do_r, clr;
    h = m_held; w = m_word; t = m_tgt; p = m_ptr; s = m_stall;
    do_x = 0; do_r = 0; clr = 0;
    if (!rst_n) begin
      h = 0; w = '0; t = 0; p = 0; s = 0; clr = 1;
    end else if (!m_held) begin
      if (in_valid && chan_en != 4'b0000) begin
        h = 1; w = in_data; s = 0; t = m_first(m_ptr, chan_en);
      end
    end else if (chan_en[m_tgt] && out_ready[m_tgt]) begin
      h = 0; p = (m_tgt + 1) % 4; s = 0; do_x = 1;
    end else if (chan_en == 4'b0000) begin
      s = m_stall;
    end else if (!chan_en[m_tgt]) begin
      t = m_first(m_tgt + 1, chan_en); s = 0; do_r = 1;
    end else if (TIMEOUT != 0) begin
      s = m_stall + 1;
      if (s == TIMEOUT) begin
        t = m_first(m_tgt + 1, chan_en); s = 0; do_r = 1;
      end
    end
    @(posedge clk);
`ifdef DEMUX_RR_DISPATCHER_STATS_EN
    if (clr) begin
      for (int i = 0; i < 4; i++) m_xfer[i] = 0;
      m_rr = 0;
    end
    if (do_x && m_xfer[m_tgt] < SAT) m_xfer[m_tgt]++;
    if (do_r && m_rr < SAT) m_rr++;
`endif
    m_held = h; m_word = w; m_tgt = t; m_ptr = p; m_stall = s;
    #1;
    check_all();
  endtask

  // Offer a word until accepted (bounded).
  task automatic push(input logic [7:0] d);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int n = 0; n < 64 && !ok; n++) begin
      ok = in_ready;
      step();
    end
    in_valid = 1'b0;
    chk("push_accepted", 32'(ok), 32'd1);
  endtask

  // Run until the held word leaves (bounded).
  task automatic wait_idle();
    for (int n = 0; n < 64 && busy; n++) step();
    chk("drained", 32'(busy), 32'd0);
  endtask

  logic [7:0] t1_data [5];
  int         t1_sel  [5];
  int         t2_sel  [3];

  initial begin
    m_held = 0; m_word = '0; m_tgt = 0; m_ptr = 0; m_stall = 0; m_rr = 0;
    for (int i = 0; i < 4; i++) m_xfer[i] = 0;
    t1_data = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    t1_sel  = '{0, 1, 2, 3, 0};
    t2_sel  = '{1, 3, 1};

    // Reset.
    rst_n = 1'b0; chan_en = 4'b0000; in_valid = 1'b0; in_data = '0; out_ready = 4'b0000;
    #2;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chan_en = 4'b1111;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // All channels enabled and ready: plain round robin.
    out_ready = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      push(t1_data[i]);
      chk("t1_sel", 32'(sel), 32'(t1_sel[i]));
      chk("t1_data", 32'(out_data), 32'(t1_data[i]));
      chk("t1_in_ready_busy", 32'(in_ready), 32'd0);
      wait_idle();
    end

    // Only channels 1 and 3 enabled.
    chan_en = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      push(8'(8'h30 + i));
      chk("t2_sel", 32'(sel), 32'(t2_sel[i]));
      wait_idle();
    end

    // Move the pointer back to 0 via channel 3, then stall channel 0.
    chan_en = 4'b1000;
    push(8'h77);
    wait_idle();
    chan_en = 4'b0011; out_ready = 4'b0010;
    push(8'h5C);
    chk("t3_first", 32'(out_valid), 32'b0001);
    for (int i = 1; i < 15; i++) begin
      step();
      chk("t3_stall", 32'(out_valid), 32'b0001);
    end
    step();
    chk("t3_reroute", 32'(out_valid), 32'b0010);
    step();
    chk("t3_delivered", 32'(busy), 32'd0);
    chan_en = 4'b1111; out_ready = 4'b0000;
    push(8'h5D);
    chk("t3_ptr", 32'(sel), 32'd2);
    out_ready = 4'b1111;
    wait_idle();

    // All channels disabled while holding, then only channel 3 enabled.
    chan_en = 4'b0100; out_ready = 4'b0000;
    push(8'h42);
    chk("t4_sel", 32'(sel), 32'd2);
    chan_en = 4'b0000;
    step();
    chk("t4_err", 32'(err_no_chan), 32'd1);
    chk("t4_out_valid", 32'(out_valid), 32'd0);
    chk("t4_in_ready", 32'(in_ready), 32'd0);
    chan_en = 4'b1000;
    step();
    chk("t4_sel_moved", 32'(sel), 32'd3);
    out_ready = 4'b1000;
    step();
    chk("t4_delivered", 32'(busy), 32'd0);

    // Five words to channel 0.
    chan_en = 4'b0001; out_ready = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      push(8'(8'h60 + i));
      wait_idle();
    end
`ifdef DEMUX_RR_DISPATCHER_STATS_EN
    chk("t6_xfer_sat", 32'(xfer_cnt[CW-1:0]), 32'(SAT));
`endif

    // Reset while holding a word.
    chan_en = 4'b1111; out_ready = 4'b0000;
    push(8'hFF);
    rst_n = 1'b0;
    step();
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_sel", 32'(sel), 32'd0);
    rst_n = 1'b1; out_ready = 4'b1111; chan_en = 4'b0110;
    push(8'h33);
    chk("t5_next_sel", 32'(sel), 32'd1);
    wait_idle();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      chan_en   = ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom);
      in_valid  = 1'($urandom);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
